// File: rtl/gpu_pa_pkg.sv
// rtl/gpu_pa_pkg.sv - shared topology encodings and defaults for primitive assembly
package gpu_pa_pkg;

    localparam logic [1:0] PA_LIST  = 2'd0;
    localparam logic [1:0] PA_STRIP = 2'd1;
    localparam logic [1:0] PA_FAN   = 2'd2;

    localparam int PA_DATA_W   = 32;
    localparam int PA_NUM_ATTR = 4;

    // Encoding 3 is reserved and behaves as a plain list.
    function automatic logic [1:0] pa_topo(input logic [1:0] m);
        return (m == PA_STRIP || m == PA_FAN) ? m : PA_LIST;
    endfunction

endpackage

// File: rtl/pa_out_stage.sv
// rtl/pa_out_stage.sv - valid/ready output register that holds its payload while stalled
module pa_out_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] data_in,
    input  logic         ready_in,
    output logic         ready,
    output logic         valid,
    output logic [W-1:0] data
);

    // Free to take a new payload when empty or when the current one leaves this cycle.
    assign ready = !valid || ready_in;

    // Load wins over drain so a transfer and a new triangle can share a cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= data_in;
        end else if (ready_in) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/primitive_assembly_topo.sv
// rtl/primitive_assembly_topo.sv - groups a vertex stream into list, strip or fan triangles
module primitive_assembly_topo
    import gpu_pa_pkg::*;
#(
    parameter int DATA_W   = PA_DATA_W,
    parameter int NUM_ATTR = PA_NUM_ATTR,
    parameter int ID_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 mode,
    input  logic                       valid_in,
    input  logic                       restart_in,
    input  logic [DATA_W*NUM_ATTR-1:0] vertex_in,
    output logic                       ready_out,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic [DATA_W*NUM_ATTR-1:0] v0,
    output logic [DATA_W*NUM_ATTR-1:0] v1,
    output logic [DATA_W*NUM_ATTR-1:0] v2,
    output logic [ID_W-1:0]            prim_id
);

    localparam int VW = DATA_W * NUM_ATTR;
    localparam int OW = 3 * VW + ID_W;

    logic [VW-1:0]   slot_a;
    logic [VW-1:0]   slot_b;
    logic [1:0]      cnt;
    logic            parity;
    logic [1:0]      mode_q;
    logic [ID_W-1:0] id_cnt;

    logic            stage_ready;
    logic            accept;
    logic            emit;
    logic [1:0]      topo;
    logic [VW-1:0]   t0;
    logic [VW-1:0]   t1;
    logic [VW-1:0]   t2;
    logic [OW-1:0]   stage_data;

    // Every vertex waits for the output stage, even ones that only fill the window.
    assign accept = valid_in && stage_ready;
    assign emit   = accept && !restart_in && (cnt == 2'd2);
    assign topo   = pa_topo(mode_q);

    // Odd strip triangles swap their first two vertices to keep a consistent winding.
    always_comb begin
        t0 = slot_a;
        t1 = slot_b;
        t2 = vertex_in;
        if (topo == PA_STRIP && parity) begin
            t0 = slot_b;
            t1 = slot_a;
        end
    end

    // Vertex window, topology latch and strip parity advance on each accepted vertex.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_a <= '0;
            slot_b <= '0;
            cnt    <= 2'd0;
            parity <= 1'b0;
            mode_q <= PA_LIST;
        end else if (accept) begin
            if (restart_in || cnt == 2'd0) begin
                mode_q <= mode;
            end
            if (restart_in) begin
                slot_a <= vertex_in;
                cnt    <= 2'd1;
                parity <= 1'b0;
            end else begin
                case (cnt)
                    2'd0: begin
                        slot_a <= vertex_in;
                        cnt    <= 2'd1;
                    end
                    2'd1: begin
                        slot_b <= vertex_in;
                        cnt    <= 2'd2;
                    end
                    default: begin
                        case (topo)
                            PA_STRIP: begin
                                slot_a <= slot_b;
                                slot_b <= vertex_in;
                                parity <= ~parity;
                            end
                            PA_FAN: begin
                                slot_b <= vertex_in;
                            end
                            default: begin
                                cnt <= 2'd0;
                            end
                        endcase
                    end
                endcase
            end
        end
    end

    // Primitive counter survives restarts and wraps naturally at its width.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_cnt <= '0;
        end else if (emit) begin
            id_cnt <= id_cnt + 1'b1;
        end
    end

    pa_out_stage #(
        .W(OW)
    ) u_out (
        .clk     (clk),
        .rst     (rst),
        .load    (emit),
        .data_in ({id_cnt, t2, t1, t0}),
        .ready_in(ready_in),
        .ready   (stage_ready),
        .valid   (valid_out),
        .data    (stage_data)
    );

    assign ready_out = stage_ready;
    assign v0        = stage_data[0 +: VW];
    assign v1        = stage_data[VW +: VW];
    assign v2        = stage_data[2*VW +: VW];
    assign prim_id   = stage_data[3*VW +: ID_W];

endmodule

// File: doc/primitive_assembly_topo.md
# primitive_assembly_topo

Parametrised successor to the triangle-list primitive assembler. It sits between the vertex post-transform stage and triangle setup. It groups an incoming vertex stream into triangles under a selectable topology: list, strip or fan. Strip restart is supported, strip winding is preserved, and the output uses full valid/ready backpressure so setup can stall assembly without losing vertices.

## Interface
Parameters:
- DATA_W, 32, width of one vertex attribute component
- NUM_ATTR, 4, components per vertex (x, y, z, w, ...); vertex bus width VW = DATA_W*NUM_ATTR, component k at bits [k*DATA_W +: DATA_W]
- ID_W, 16, width of primitive counter

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  asynchronous, active-low reset
- mode  in  2  topology: 0 list, 1 strip, 2 fan, 3 treated as list
- valid_in  in  1  vertex valid
- restart_in  in  1  qualified by valid_in; accepted vertex begins a new sequence
- vertex_in  in  VW  incoming vertex
- ready_out  out  1  vertex accepted when valid_in && ready_out
- valid_out  out  1  triangle valid
- ready_in  in  1  downstream ready; triangle transferred when valid_out && ready_in
- v0, v1, v2  out  VW each  triangle vertices, in winding order
- prim_id  out  ID_W  index of the presented triangle

## Operation
- Internal state:
  - slot A, slot B (VW each)
  - cnt: 0..2 vertices held
  - parity bit (strip)
  - mode_q: latched topology
- mode is sampled into mode_q only when a vertex is accepted with cnt==0 or restart_in=1. Changes at any other time are ignored.
- Accepted vertex V with restart_in=1: A<=V, cnt<=1, parity<=0. No triangle is emitted, regardless of prior cnt, and partial vertices are discarded.
- Accepted vertex V with cnt==0: A<=V, cnt<=1.
- Accepted vertex V with cnt==1: B<=V, cnt<=2.
- Accepted vertex V with cnt==2 emits a triangle, per mode_q:
  - list: emit (A,B,V); cnt<=0.
  - strip, parity 0: emit (A,B,V). Parity 1: emit (B,A,V). Then A<=B, B<=V, parity toggles, cnt stays 2.
  - fan: emit (A,B,V); B<=V; A (anchor) unchanged; cnt stays 2.
- prim_id: each emitted triangle carries the current counter value, and the counter then increments. It wraps from 2^ID_W-1 to 0 and is not cleared by restart.
- ready_out = !valid_out || ready_in (combinational).
  - Vertices that do not complete a triangle are also held off while a stalled triangle is pending. This keeps ordering simple.

## Timing
- Reset values:
  - valid_out=0; v0, v1, v2=0; prim_id=0
  - cnt=0, parity=0, mode_q=0, A=B=0
  - ready_out reads 1 after reset while valid_out=0.
- Latency: a triangle appears on v0..v2 with valid_out=1 the cycle after its completing vertex is accepted.
- Throughput: list gives 1 triangle per 3 accepted vertices. Strip and fan, once primed, give 1 triangle per accepted vertex, back-to-back with no bubble while ready_in=1.
- Stall: while valid_out && !ready_in, v0..v2, prim_id and valid_out hold stable, ready_out=0, and no state changes.
- Transfer and new triangle in the same cycle (valid_out && ready_in && completing accept): the output registers load the new triangle and valid_out stays 1.
- Transfer with no new triangle: valid_out<=0 next cycle.
- Reset asserted mid-sequence or mid-stall: all state returns to reset values immediately. The pending triangle and partial vertices are dropped.

## Structure
- Package gpu_pa_pkg holds the mode encodings PA_LIST=0, PA_STRIP=1, PA_FAN=2 and the default DATA_W and NUM_ATTR.
- One sub-module is natural: pa_out_stage, a VW*3+ID_W wide valid/ready output register with hold-on-stall.
- Vertex window, counter and topology logic stay in the top module.

## Test plan
Vertices Vi have x=0x10*i, other components 0. ready_in=1 unless stated.
- List, V0..V5 back-to-back -> two triangles (V0,V1,V2) prim_id 0 and (V3,V4,V5) prim_id 1, each one cycle after its third vertex.
- Strip, V0..V4 -> (V0,V1,V2), (V2,V1,V3), (V2,V3,V4) on consecutive cycles with prim_id 0,1,2.
- Fan, V0..V4 -> (V0,V1,V2), (V0,V2,V3), (V0,V3,V4).
- Strip V0,V1,V2,V3, then V4 with restart_in=1, then V5,V6 -> triangles (V0,V1,V2), (V2,V1,V3), then (V4,V5,V6) with parity reset (not swapped).
- Strip streaming with ready_in=0 for 3 cycles after the first triangle -> outputs hold (V0,V1,V2), ready_out=0, no vertex lost; on release the sequence continues exactly as in scenario 2.
- Apply rst low mid-strip with a stalled triangle, then list V0..V2 -> valid_out drops immediately, prim_id restarts at 0, and the first triangle is (V0,V1,V2) in list mode.
